// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage feeding issue. Holds the PC, keeps at most one
// request outstanding to the instruction cache, predecodes each returned word
// to pick the next PC, and queues {inst, pc, pred} for the back end. The queue
// head is offered to issue every cycle the back end can take it. A flush from
// ROB commit empties the queue and redirects the PC.
//
// Optional feature: define FETCH_BHT_EN for a 2-bit saturating-counter branch
// history table. Without it, conditional branches are predicted not-taken and
// the bp_* inputs are ignored.
//
// Parameters
//   IQ_LOG   log2 of instruction-queue depth
//   BHT_LOG  log2 of BHT entries (FETCH_BHT_EN only)
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-low reset
//   rdy                 global ready; low freezes all state
//   icache_req/addr     request valid and fetch address (the PC register)
//   icache_valid/inst   one-cycle response strobe and returned word
//   backend_full        issue cannot accept an instruction this cycle
//   inst_valid          head entry offered and consumed this cycle
//   inst/pc/pred_to_issue  head entry fields
//   flush, flush_pc     redirect from ROB commit
//   bp_update/pc/taken  resolved branch outcome for the BHT
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int IQ_LOG  = 3,
  parameter int BHT_LOG = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_valid,
  input  logic [31:0] icache_inst,
  input  logic        backend_full,
  output logic        inst_valid,
  output logic [31:0] inst_to_issue,
  output logic [31:0] pc_to_issue,
  output logic        pred_to_issue,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        bp_update,
  input  logic [31:0] bp_pc,
  input  logic        bp_taken
);

  localparam int IQ_DEPTH = 1 << IQ_LOG;
  localparam logic [IQ_LOG:0] IQ_FULL = (IQ_LOG+1)'(IQ_DEPTH);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP
  } state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } iq_entry_t;

  iq_entry_t          iq [IQ_DEPTH];
  logic [IQ_LOG-1:0]  head;
  logic [IQ_LOG-1:0]  tail;
  logic [IQ_LOG:0]    count;
  logic [31:0]        pc;
  state_t             state;
  logic               req_q;

  logic               push;
  logic               pop;
  logic               br_taken;
  logic [6:0]         opcode;
  logic [31:0]        j_imm;
  logic [31:0]        b_imm;
  logic [31:0]        next_pc;
  logic               next_pred;

  // ---------------------------------------------------------------------------
  // Branch direction source
  // ---------------------------------------------------------------------------
`ifdef FETCH_BHT_EN
  logic [1:0] bht [1 << BHT_LOG];

  assign br_taken = bht[pc[BHT_LOG+1:2]][1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < (1 << BHT_LOG); i++) bht[i] <= 2'b01;
    end else if (rdy && bp_update) begin
      if (bp_taken) begin
        if (bht[bp_pc[BHT_LOG+1:2]] != 2'b11)
          bht[bp_pc[BHT_LOG+1:2]] <= bht[bp_pc[BHT_LOG+1:2]] + 2'b01;
      end else begin
        if (bht[bp_pc[BHT_LOG+1:2]] != 2'b00)
          bht[bp_pc[BHT_LOG+1:2]] <= bht[bp_pc[BHT_LOG+1:2]] - 2'b01;
      end
    end
  end

  // Only the index bits of bp_pc select a counter.
  logic unused_bp;
  assign unused_bp = ^{bp_pc[31:BHT_LOG+2], bp_pc[1:0]};
`else
  assign br_taken = 1'b0;

  logic unused_bp;
  assign unused_bp = ^{bp_update, bp_pc, bp_taken};
`endif

  // ---------------------------------------------------------------------------
  // Predecode of the returned word
  // ---------------------------------------------------------------------------
  assign opcode = icache_inst[6:0];
  assign j_imm  = {{11{icache_inst[31]}}, icache_inst[31], icache_inst[19:12],
                   icache_inst[20], icache_inst[30:21], 1'b0};
  assign b_imm  = {{19{icache_inst[31]}}, icache_inst[31], icache_inst[7],
                   icache_inst[30:25], icache_inst[11:8], 1'b0};

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    next_pc   = pc + 32'd4;
    next_pred = 1'b0;
    if (opcode == OP_JAL) begin
      next_pc   = pc + j_imm;
      next_pred = 1'b1;
    end else if (opcode == OP_BRANCH && br_taken) begin
      next_pc   = pc + b_imm;
      next_pred = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue interface
  // ---------------------------------------------------------------------------
  assign inst_valid    = rst && rdy && (count != '0) && !backend_full && !flush;
  assign inst_to_issue = iq[head].inst;
  assign pc_to_issue   = iq[head].pc;
  assign pred_to_issue = iq[head].pred;

  assign icache_req  = req_q;
  assign icache_addr = pc;

  assign push = (state == S_REQ) && icache_valid;
  assign pop  = inst_valid;

  // ---------------------------------------------------------------------------
  // PC, FSM and queue
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc    <= '0;
      state <= S_IDLE;
      req_q <= 1'b0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      // NOTE: queue storage is reset so the head outputs read zero out of
      // reset rather than X; with 8 entries the cost is negligible.
      for (int i = 0; i < IQ_DEPTH; i++) iq[i] <= '0;
    end else if (rdy) begin
      if (flush) begin
        // Redirect wins over any push, pop or normal transition.
        head  <= '0;
        tail  <= '0;
        count <= '0;
        pc    <= flush_pc;
        req_q <= 1'b0;
        // A request still in flight must have its response swallowed.
        if (state == S_REQ && !icache_valid) state <= S_DROP;
        else                                 state <= S_IDLE;
      end else begin
        if (push) begin
          iq[tail] <= '{inst: icache_inst, pc: pc, pred: next_pred};
          tail     <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;

        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase

        case (state)
          S_IDLE: begin
            if (count != IQ_FULL) begin
              state <= S_REQ;
              req_q <= 1'b1;
            end
          end
          S_REQ: begin
            if (icache_valid) begin
              pc    <= next_pc;
              state <= S_IDLE;
              req_q <= 1'b0;
            end
          end
          S_DROP: begin
            if (icache_valid) state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
            req_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A small instruction-cache model answers each
// request after a programmable latency from a fixed program image; monitors
// log issued entries and request addresses, which are compared against a
// hand-written next-PC table for the program.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

`ifdef FETCH_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_valid;
  logic [31:0] icache_inst;
  logic        backend_full;
  logic        inst_valid;
  logic [31:0] inst_to_issue;
  logic [31:0] pc_to_issue;
  logic        pred_to_issue;
  logic        flush;
  logic [31:0] flush_pc;
  logic        bp_update;
  logic [31:0] bp_pc;
  logic        bp_taken;

  always #5 clk = ~clk;

  fetch_unit #(.IQ_LOG(3), .BHT_LOG(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .icache_req    (icache_req),
    .icache_addr   (icache_addr),
    .icache_valid  (icache_valid),
    .icache_inst   (icache_inst),
    .backend_full  (backend_full),
    .inst_valid    (inst_valid),
    .inst_to_issue (inst_to_issue),
    .pc_to_issue   (pc_to_issue),
    .pred_to_issue (pred_to_issue),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .bp_update     (bp_update),
    .bp_pc         (bp_pc),
    .bp_taken      (bp_taken)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Program image: JAL x0,+16 at 0x20, BEQ x0,x0,-8 at 0x40, a marker word at
  // 0x200, and elsewhere ADDI words whose immediate encodes the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h20:  return 32'h0100006F;
      32'h40:  return 32'hFE000CE3;
      32'h200: return 32'h7FF00013;
      default: return {a[13:2], 20'h00093};
    endcase
  endfunction

  // Expected successor PC for this program (BHT trained taken at 0x40).
  function automatic logic [31:0] model_next(input logic [31:0] a);
    if (a == 32'h20) return 32'h30;
    if (a == 32'h40) return BHT_ON ? 32'h38 : 32'h44;
    return a + 32'd4;
  endfunction

  function automatic logic model_pred(input logic [31:0] a);
    if (a == 32'h20) return 1'b1;
    if (a == 32'h40) return BHT_ON;
    return 1'b0;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } iss_t;

  iss_t        issue_log[$];
  logic [31:0] req_log[$];
  logic        req_prev = 1'b0;

  always @(negedge clk) begin
    if (inst_valid) issue_log.push_back({pc_to_issue, inst_to_issue, pred_to_issue});
    if (icache_req && !req_prev) req_log.push_back(icache_addr);
    req_prev <= icache_req;
  end

  // ---------------------------------------------------------------------------
  // Instruction cache model: latches a request when first seen and answers
  // cache_lat cycles later, even if the request has since been withdrawn.
  // ---------------------------------------------------------------------------
  int          cache_lat = 1;
  logic        pend = 1'b0;
  int          wcnt = 0;
  logic [31:0] paddr = '0;

  initial begin
    icache_valid = 1'b0;
    icache_inst  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        pend         = 1'b0;
        icache_valid = 1'b0;
      end else if (icache_valid) begin
        icache_valid = 1'b0;
      end else if (pend) begin
        wcnt++;
        if (wcnt >= cache_lat) begin
          icache_valid = 1'b1;
          icache_inst  = imem(paddr);
          pend         = 1'b0;
        end
      end else if (icache_req) begin
        pend  = 1'b1;
        wcnt  = 0;
        paddr = icache_addr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_reqs(input int n, input int budget);
    int k = 0;
    while (req_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("req_timeout", 32'(req_log.size() >= n), 32'd1);
  endtask

  task automatic wait_iss(input int n, input int budget);
    int k = 0;
    while (issue_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("iss_timeout", 32'(issue_log.size() >= n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] exp_pc;
    int          n_before;
    int          n0;
    int          nr;

    rst          = 1'b0;
    rdy          = 1'b1;
    backend_full = 1'b0;
    flush        = 1'b0;
    flush_pc     = '0;
    bp_update    = 1'b0;
    bp_pc        = '0;
    bp_taken     = 1'b0;

    // Reset state
    tick();
    check("rst_req",  icache_req,    32'd0);
    check("rst_addr", icache_addr,   32'd0);
    check("rst_ival", inst_valid,    32'd0);
    check("rst_inst", inst_to_issue, 32'd0);
    check("rst_pc",   pc_to_issue,   32'd0);
    check("rst_pred", pred_to_issue, 32'd0);

    // Release reset; train the BHT taken twice for the branch at 0x40.
    rst       = 1'b1;
    bp_update = 1'b1;
    bp_pc     = 32'h40;
    bp_taken  = 1'b1;
    tick();
    check("c1_req",  icache_req,  32'd1);
    check("c1_addr", icache_addr, 32'd0);
    check("c1_ival", inst_valid,  32'd0);
    tick();
    bp_update = 1'b0;
    check("c2_ival", inst_valid, 32'd0);
    tick();
    check("c3_ival", inst_valid,    32'd1);
    check("c3_pc",   pc_to_issue,   32'd0);
    check("c3_pred", pred_to_issue, 32'd0);
    check("c3_inst", inst_to_issue, imem(32'd0));

    // Straight-line fetch through the JAL and the branch.
    wait_reqs(15, 200);
    exp_pc = '0;
    for (int i = 0; i < 15 && i < req_log.size(); i++) begin
      check($sformatf("req_addr%0d", i), req_log[i], exp_pc);
      exp_pc = model_next(exp_pc);
    end
    wait_iss(14, 100);
    exp_pc = '0;
    for (int i = 0; i < 14 && i < issue_log.size(); i++) begin
      check($sformatf("iss_pc%0d", i),   issue_log[i].pc,   exp_pc);
      check($sformatf("iss_inst%0d", i), issue_log[i].inst, imem(exp_pc));
      check($sformatf("iss_pred%0d", i), 32'(issue_log[i].pred), 32'(model_pred(exp_pc)));
      exp_pc = model_next(exp_pc);
    end

    // Back-end stall fills the queue and stops requests.
    backend_full = 1'b1;
    n_before     = issue_log.size();
    repeat (40) tick();
    check("stall_req",  icache_req, 32'd0);
    check("stall_iss",  32'(issue_log.size() - n_before), 32'd0);
    check("stall_occ",  32'(req_log.size() - issue_log.size()), 32'd8);

    // Release: eight entries issue on consecutive cycles, in program order.
    exp_pc       = issue_log[issue_log.size()-1].pc;
    backend_full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_pc = model_next(exp_pc);
      check($sformatf("drain_ival%0d", i), inst_valid,  32'd1);
      check($sformatf("drain_pc%0d", i),   pc_to_issue, exp_pc);
      tick();
    end

    // Fill again, then hold rdy low: nothing moves.
    backend_full = 1'b1;
    repeat (40) tick();
    exp_pc = issue_log[issue_log.size()-1].pc;
    repeat (9) exp_pc = model_next(exp_pc);
    rdy          = 1'b0;
    backend_full = 1'b0;
    n_before     = issue_log.size();
    #1;
    check("rdy0_ival", inst_valid, 32'd0);
    tick();
    tick();
    check("rdy0_addr",  icache_addr, exp_pc);
    check("rdy0_req",   icache_req,  32'd0);
    check("rdy0_nopop", 32'(issue_log.size() - n_before), 32'd0);

    // Flush on a full queue with the back end ready: nothing issues.
    rdy       = 1'b1;
    flush     = 1'b1;
    flush_pc  = 32'h200;
    cache_lat = 2;
    #1;
    check("fl1_ival", inst_valid, 32'd0);
    n0 = issue_log.size();
    tick();
    flush = 1'b0;
    #1;
    check("fl1_empty", inst_valid, 32'd0);
    check("fl1_idle",  icache_req, 32'd0);
    tick();
    check("fl1_req",  icache_req,  32'd1);
    check("fl1_addr", icache_addr, 32'h200);

    // Flush while in REQ; the stale response arrives two cycles later.
    flush    = 1'b1;
    flush_pc = 32'h100;
    #1;
    check("fl2_ival", inst_valid, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("fl2_drop_req",  icache_req, 32'd0);
    check("fl2_drop_ival", inst_valid, 32'd0);
    nr = req_log.size();
    wait_reqs(nr + 1, 50);
    if (req_log.size() > nr) check("fl2_addr", req_log[nr], 32'h100);
    wait_iss(n0 + 1, 50);
    if (issue_log.size() > n0) begin
      check("fl2_first_pc",   issue_log[n0].pc,   32'h100);
      check("fl2_first_inst", issue_log[n0].inst, imem(32'h100));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
